// File: rtl/mem_sram_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mem_sram_ctrl_pkg
//  Description : Shared types and constants for the 32-bit-to-16-bit SRAM
//                access controller: FSM state encoding, default data-segment
//                base address and SRAM bus widths.
//  Revision    : 1.0 - initial release
// ============================================================================
package mem_sram_ctrl_pkg;

    // Byte address that maps onto SRAM half-word pair 0.
    localparam int unsigned DEFAULT_DATA_BASE = 1024;

    // External SRAM: 18-bit half-word address, 16-bit data bus.
    localparam int unsigned SRAM_AW = 18;
    localparam int unsigned SRAM_DW = 16;

    // A 32-bit access is split into a LOW half-word phase and a HIGH
    // half-word phase, followed by a single-cycle DONE handshake.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOW  = 2'd1,
        HIGH = 2'd2,
        DONE = 2'd3
    } state_t;

endpackage : mem_sram_ctrl_pkg
`default_nettype wire

// File: rtl/mem_sram_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : mem_sram_ctrl
//  Description : MEM-stage load/store controller for a 16-bit asynchronous
//                SRAM. Each 32-bit access is performed as two half-word
//                phases (LOW then HIGH) of WAIT_CYCLES cycles each, followed
//                by one DONE cycle in which ready is raised. The pipeline
//                freezes while ready is low.
//
//  Ports       : clk, rst        - clock (rising edge), synchronous reset
//                wr_en, rd_en    - store / load request (store wins if both)
//                address, wdata  - byte address and store data
//                rdata           - load data, held until the next load
//                ready           - access complete (freeze = !ready)
//                sram_addr       - SRAM half-word address
//                sram_dq_out/oe  - SRAM write data and its drive enable
//                sram_dq_in      - SRAM read data
//                sram_we_n       - SRAM write strobe, active-low
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_sram_ctrl
    import mem_sram_ctrl_pkg::*;
#(
    parameter int unsigned WAIT_CYCLES = 2,                 // legal 1..7
    parameter int unsigned DATA_BASE   = DEFAULT_DATA_BASE
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               wr_en,
    input  logic               rd_en,
    input  logic [31:0]        address,
    input  logic [31:0]        wdata,
    output logic [31:0]        rdata,
    output logic               ready,
    output logic [SRAM_AW-1:0] sram_addr,
    output logic [SRAM_DW-1:0] sram_dq_out,
    output logic               sram_dq_oe,
    input  logic [SRAM_DW-1:0] sram_dq_in,
    output logic               sram_we_n
);

    localparam logic [2:0] c_LAST_CNT = 3'(WAIT_CYCLES - 1);

    state_t      r_state;
    state_t      w_next_state;
    logic [2:0]  r_cnt;
    logic        r_is_write;
    logic [16:0] r_word;
    logic [31:0] r_wdata;
    logic [31:0] r_rdata;

    logic        w_req;
    logic        w_phase_end;
    logic [16:0] w_word_in;

    assign w_req       = wr_en | rd_en;
    assign w_phase_end = (r_cnt == c_LAST_CNT);

    // Word index wraps modulo 2^17; addresses below DATA_BASE simply alias.
    assign w_word_in = 17'((address - DATA_BASE) >> 2);

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and SRAM/handshake outputs
    // ------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        ready        = 1'b0;
        sram_addr    = '0;
        sram_dq_out  = '0;
        sram_dq_oe   = 1'b0;
        sram_we_n    = 1'b1;

        unique case (r_state)
            IDLE: begin
                // A request seen in IDLE freezes the pipeline immediately.
                ready = ~w_req;
                if (w_req) begin
                    w_next_state = LOW;
                end
            end
            LOW: begin
                sram_addr = {r_word, 1'b0};
                if (r_is_write) begin
                    sram_dq_oe  = 1'b1;
                    sram_we_n   = 1'b0;
                    sram_dq_out = r_wdata[15:0];
                end
                if (w_phase_end) begin
                    w_next_state = HIGH;
                end
            end
            HIGH: begin
                sram_addr = {r_word, 1'b1};
                if (r_is_write) begin
                    sram_dq_oe  = 1'b1;
                    sram_we_n   = 1'b0;
                    sram_dq_out = r_wdata[31:16];
                end
                if (w_phase_end) begin
                    w_next_state = DONE;
                end
            end
            DONE: begin
                // Requests here are ignored; they start from IDLE next cycle.
                ready        = 1'b1;
                w_next_state = IDLE;
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Phase counter, request latch and load-data capture
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt      <= '0;
            r_is_write <= 1'b0;
            r_word     <= '0;
            r_wdata    <= '0;
            r_rdata    <= '0;
        end else begin
            // Counter restarts on every state change so each phase sees 0..N-1.
            if (w_next_state != r_state) begin
                r_cnt <= '0;
            end else if (r_state == LOW || r_state == HIGH) begin
                r_cnt <= r_cnt + 3'd1;
            end

            // Operation is frozen at IDLE->LOW; later input changes are ignored.
            if (r_state == IDLE && w_req) begin
                r_is_write <= wr_en;
                r_word     <= w_word_in;
                r_wdata    <= wdata;
            end

            // Sample the SRAM at the end of each phase, when data has settled.
            if (!r_is_write && w_phase_end) begin
                if (r_state == LOW) begin
                    r_rdata[15:0] <= sram_dq_in;
                end
                if (r_state == HIGH) begin
                    r_rdata[31:16] <= sram_dq_in;
                end
            end
        end
    end

    assign rdata = r_rdata;

endmodule : mem_sram_ctrl
`default_nettype wire

// File: tb/tb_mem_sram_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_sram_ctrl
//  Description : Directed self-checking bench for mem_sram_ctrl with a
//                behavioural 16-bit SRAM attached. WAIT_CYCLES = 2, so an
//                access shows ready=0 in cycles 0..4 and ready=1 in cycle 5.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_sram_ctrl;

    logic        clk;
    logic        rst;
    logic        wr_en;
    logic        rd_en;
    logic [31:0] address;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        ready;
    logic [17:0] sram_addr;
    logic [15:0] sram_dq_out;
    logic        sram_dq_oe;
    logic [15:0] sram_dq_in;
    logic        sram_we_n;

    int n_checks;
    int n_errors;

    mem_sram_ctrl #(
        .WAIT_CYCLES (2),
        .DATA_BASE   (1024)
    ) u_dut (
        .clk         (clk),
        .rst         (rst),
        .wr_en       (wr_en),
        .rd_en       (rd_en),
        .address     (address),
        .wdata       (wdata),
        .rdata       (rdata),
        .ready       (ready),
        .sram_addr   (sram_addr),
        .sram_dq_out (sram_dq_out),
        .sram_dq_oe  (sram_dq_oe),
        .sram_dq_in  (sram_dq_in),
        .sram_we_n   (sram_we_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural SRAM: synchronous write on the strobe, combinational read.
    logic [15:0] sram_mem [0:262143];
    always @(posedge clk) begin
        if (!sram_we_n) begin
            sram_mem[sram_addr] <= sram_dq_out;
        end
    end
    assign sram_dq_in = sram_mem[sram_addr];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // One full access starting in the current (IDLE) cycle. Inputs are
    // scrambled after the launch edge to prove they are latched. With hold=1
    // the request stays up through DONE with address switched to next_addr.
    task automatic do_access(input string tag, input logic wr, input logic rd,
                             input logic [31:0] addr, input logic [31:0] data,
                             input logic [17:0] exp_base, input logic [31:0] exp_rdata,
                             input logic hold, input logic [31:0] next_addr);
        logic exp_wr;
        exp_wr  = wr;  // store wins when both are requested
        wr_en   = wr;
        rd_en   = rd;
        address = addr;
        wdata   = data;
        #1;
        check($sformatf("%s c0 ready", tag), {31'd0, ready}, 32'd0);
        check($sformatf("%s c0 sram_addr", tag), {14'd0, sram_addr}, 32'd0);
        for (int c = 1; c <= 4; c++) begin
            next_cycle();
            if (c == 1) begin
                wr_en   = ~wr;
                rd_en   = ~rd;
                address = 32'hFFFF_FFF0;
                wdata   = ~data;
                #1;
            end
            check($sformatf("%s c%0d ready", tag, c), {31'd0, ready}, 32'd0);
            check($sformatf("%s c%0d sram_addr", tag, c), {14'd0, sram_addr},
                  {14'd0, exp_base + ((c >= 3) ? 18'd1 : 18'd0)});
            check($sformatf("%s c%0d we_n", tag, c), {31'd0, sram_we_n}, {31'd0, ~exp_wr});
            check($sformatf("%s c%0d oe", tag, c), {31'd0, sram_dq_oe}, {31'd0, exp_wr});
            if (exp_wr) begin
                check($sformatf("%s c%0d dq_out", tag, c), {16'd0, sram_dq_out},
                      {16'd0, (c >= 3) ? data[31:16] : data[15:0]});
            end
        end
        next_cycle();
        if (hold) begin
            wr_en   = wr;
            rd_en   = rd;
            address = next_addr;
            wdata   = data;
        end else begin
            wr_en = 1'b0;
            rd_en = 1'b0;
        end
        #1;
        check($sformatf("%s c5 ready", tag), {31'd0, ready}, 32'd1);
        check($sformatf("%s c5 sram_addr", tag), {14'd0, sram_addr}, 32'd0);
        check($sformatf("%s c5 we_n", tag), {31'd0, sram_we_n}, 32'd1);
        check($sformatf("%s c5 rdata", tag), rdata, exp_rdata);
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst      = 1'b1;
        wr_en    = 1'b0;
        rd_en    = 1'b0;
        address  = 32'd0;
        wdata    = 32'd0;
        next_cycle();
        next_cycle();
        rst = 1'b0;
        #1;

        // Reset state
        check("rst rdata", rdata, 32'd0);
        check("rst we_n", {31'd0, sram_we_n}, 32'd1);
        check("rst oe", {31'd0, sram_dq_oe}, 32'd0);
        check("rst sram_addr", {14'd0, sram_addr}, 32'd0);
        check("rst dq_out", {16'd0, sram_dq_out}, 32'd0);
        check("rst ready", {31'd0, ready}, 32'd1);

        // Store 0xDEADBEEF to 1028 -> half-words 2 (BEEF) and 3 (DEAD)
        next_cycle();
        do_access("wr1028", 1'b1, 1'b0, 32'd1028, 32'hDEAD_BEEF, 18'd2, 32'd0, 1'b0, 32'd0);

        // Load it back
        next_cycle();
        check("idle ready", {31'd0, ready}, 32'd1);
        do_access("rd1028", 1'b0, 1'b1, 32'd1028, 32'h0, 18'd2, 32'hDEAD_BEEF, 1'b0, 32'd0);

        // Both requests -> store; rdata untouched
        next_cycle();
        do_access("both1024", 1'b1, 1'b1, 32'd1024, 32'h1234_5678, 18'd0, 32'hDEAD_BEEF, 1'b0, 32'd0);
        next_cycle();
        do_access("rd1024", 1'b0, 1'b1, 32'd1024, 32'h0, 18'd0, 32'h1234_5678, 1'b0, 32'd0);

        // Reset during the second HIGH cycle of a store to 1032 (half-words 4/5).
        // Half-word 4 gets F00D during LOW; 5 gets CAFE on the first HIGH edge.
        next_cycle();
        wr_en   = 1'b1;
        address = 32'd1032;
        wdata   = 32'hCAFE_F00D;
        for (int c = 1; c <= 3; c++) begin
            next_cycle();
            wr_en = 1'b0;
        end
        next_cycle();
        check("rstmid c4 sram_addr", {14'd0, sram_addr}, 32'd5);
        check("rstmid c4 we_n", {31'd0, sram_we_n}, 32'd0);
        rst = 1'b1;
        next_cycle();
        rst = 1'b0;
        #1;
        check("rstmid we_n", {31'd0, sram_we_n}, 32'd1);
        check("rstmid oe", {31'd0, sram_dq_oe}, 32'd0);
        check("rstmid sram_addr", {14'd0, sram_addr}, 32'd0);
        check("rstmid ready", {31'd0, ready}, 32'd1);
        check("rstmid rdata", rdata, 32'd0);
        next_cycle();
        check("rstmid idle ready", {31'd0, ready}, 32'd1);
        do_access("rd1032", 1'b0, 1'b1, 32'd1032, 32'h0, 18'd4, 32'hCAFE_F00D, 1'b0, 32'd0);

        // Back-to-back loads: request held through DONE, then new address
        next_cycle();
        do_access("b2b_a", 1'b0, 1'b1, 32'd1028, 32'h0, 18'd2, 32'hDEAD_BEEF, 1'b1, 32'd1024);
        next_cycle();
        do_access("b2b_b", 1'b0, 1'b1, 32'd1024, 32'h0, 18'd0, 32'h1234_5678, 1'b0, 32'd0);
        next_cycle();
        check("b2b end ready", {31'd0, ready}, 32'd1);
        check("b2b end sram_addr", {14'd0, sram_addr}, 32'd0);
        next_cycle();
        check("b2b end rdata", rdata, 32'h1234_5678);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_mem_sram_ctrl
`default_nettype wire

// File: doc/mem_sram_ctrl.md
MEM_SRAM_CTRL -- requirements
Module: mem_sram_ctrl

Interface
REQ-001 Parameter WAIT_CYCLES, default 2, SHALL set the cycles per 16-bit SRAM phase; legal range 1..7.
REQ-002 Parameter DATA_BASE, default 1024, SHALL set the byte address that maps to SRAM word 0.
REQ-003 Ports SHALL be:
 clk  in  1  single clock, rising edge
 rst  in  1  reset, synchronous, active-high
 wr_en  in  1  MEM-stage store request (MEM_W_EN)
 rd_en  in  1  MEM-stage load request (MEM_R_EN)
 address  in  32  byte address (ALU result)
 wdata  in  32  store data (ST_val)
 rdata  out  32  load data
 ready  out  1  access complete; pipeline freeze = !ready
 sram_addr  out  18  SRAM half-word address
 sram_dq_out  out  16  SRAM write data
 sram_dq_oe  out  1  drive enable for SRAM DQ
 sram_dq_in  in  16  SRAM read data
 sram_we_n  out  1  SRAM write strobe, active-low

Function
REQ-004 FSM states SHALL be IDLE, LOW, HIGH, DONE.
REQ-005 IDLE SHALL go to LOW when wr_en or rd_en is 1 and SHALL remain in IDLE otherwise.
REQ-006 LOW SHALL last exactly WAIT_CYCLES cycles, then go to HIGH; HIGH SHALL last exactly WAIT_CYCLES cycles, then go to DONE; DONE SHALL last 1 cycle, then go to IDLE.
REQ-007 A 3-bit phase counter SHALL clear on every state entry and count cycles within LOW/HIGH.
REQ-008 ready SHALL be combinational: 1 in IDLE with no request, 0 in IDLE with a request, 0 in LOW and HIGH, 1 in DONE.
REQ-009 Latency: if cycle 0 is the first IDLE cycle with a request, ready SHALL be 1 in cycle 2*WAIT_CYCLES+1 (cycle 5 at default).
REQ-010 Operation type, address and wdata SHALL be latched on the IDLE->LOW transition; input changes after that edge SHALL be ignored until IDLE.
REQ-011 Word address SHALL be (address - DATA_BASE)>>2, modulo 2^17; no range check.
REQ-012 sram_addr SHALL be {word,1'b0} in LOW and {word,1'b1} in HIGH; it SHALL be 0 in IDLE and DONE.
REQ-013 Write: sram_dq_oe=1 and sram_we_n=0 throughout LOW and HIGH; sram_dq_out SHALL be wdata[15:0] in LOW and wdata[31:16] in HIGH.
REQ-014 Read: sram_we_n=1 and sram_dq_oe=0; rdata[15:0] SHALL capture sram_dq_in on the last LOW cycle, and rdata[31:16] on the last HIGH cycle.
REQ-015 rdata SHALL hold its value until overwritten by a later read; writes SHALL NOT modify rdata.
REQ-016 If wr_en and rd_en are both 1, the access SHALL be a write.
REQ-017 A request present in DONE SHALL NOT start an access; a request on the cycle after DONE SHALL start a new access from IDLE.
REQ-018 Outside write phases, sram_we_n SHALL be 1 and sram_dq_oe SHALL be 0.

Reset
REQ-019 On rst=1 at a clk edge, the state SHALL be IDLE and the counter and latched operation, address and wdata SHALL be 0.
REQ-020 After reset: rdata=0, sram_we_n=1, sram_dq_oe=0, sram_addr=0 and sram_dq_out=0; ready then follows REQ-008.
REQ-021 A reset asserted mid-access SHALL abort the access with no DONE cycle; the SRAM write strobe SHALL deassert on that edge.

Structure
REQ-022 A shared package SHALL hold the state enum, DATA_BASE default, SRAM_AW=18 and SRAM_DW=16.
REQ-023 The block SHALL be a single module with no sub-module; the FSM and phase counter are inline.

Verification
REQ-024 Write: address=1028, wdata=0xDEADBEEF held, WAIT=2 -> sram_addr=2 with dq=0xBEEF for 2 cycles, then sram_addr=3 with dq=0xDEAD for 2 cycles; ready=1 in cycle 5.
REQ-025 Read back address=1028 with an SRAM model -> rdata=0xDEADBEEF when ready=1, and sram_we_n=1 throughout.
REQ-026 wr_en=rd_en=1, address=1024, wdata=0x12345678 -> write performed, with dq 0x5678 then 0x1234; rdata unchanged.
REQ-027 rst=1 on the second HIGH cycle of a write -> next cycle state IDLE, sram_we_n=1 and sram_dq_oe=0; a subsequent read of that word completes normally.
REQ-028 Back-to-back loads: requests held through DONE, then a new address -> exactly two accesses, each 5 cycles ready=0 plus 1 cycle ready=1; no idle ready=1 cycle between them beyond DONE.
